// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle control unit: states, opcodes,
// ALU operation codes, datapath select codes and the decoded control bundle.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_R_WB     = 4'd7,
      S_EXEC_I   = 4'd8,
      S_I_WB     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [2:0] ALU_AND    = 3'b000;
   localparam logic [2:0] ALU_SUB    = 3'b001;
   localparam logic [2:0] ALU_LUI    = 3'b010;
   localparam logic [2:0] ALU_ADD    = 3'b100;
   localparam logic [2:0] ALU_OR     = 3'b101;
   localparam logic [2:0] ALU_MEMADD = 3'b110;
   localparam logic [2:0] ALU_FUNCT  = 3'b111;

   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic [1:0] SRCB_B     = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   typedef struct packed {
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       pcWrite;
      logic       branchEq;
      logic       branchNe;
      logic [1:0] regDst;
      logic [1:0] memToReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [2:0] aluOp;
      logic [1:0] pcSource;
      logic       instrDone;
      logic       illegalOp;
   } ctrl_t;

   function automatic logic isLegal(input logic [5:0] op);
      case (op)
         OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
         OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: isLegal = 1'b1;
         default:                               isLegal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Moore output decode for the multi-cycle controller; only the FETCH/MEM_WR
// handshake outputs look at memReady.
module multicycle_control_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] op,
   input  logic [5:0] opQ,
   input  logic       memReady,
   input  logic       reset,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.memRead  = 1'b1;
            ctrl.aluSrcB  = SRCB_FOUR;
            ctrl.aluOp    = ALU_ADD;
            ctrl.pcSource = PCSRC_ALU;
            ctrl.irWrite  = memReady;
            ctrl.pcWrite  = memReady;
         end
         S_DECODE: begin
            ctrl.aluSrcB   = SRCB_IMMSH;
            ctrl.aluOp     = ALU_ADD;
            ctrl.illegalOp = !isLegal(op);
            ctrl.instrDone = !isLegal(op);
         end
         S_MEM_ADDR: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALU_MEMADD;
         end
         S_MEM_RD: begin
            ctrl.memRead = 1'b1;
            ctrl.iorD    = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.regWrite  = 1'b1;
            ctrl.regDst    = REGDST_RT;
            ctrl.memToReg  = M2R_MDR;
            ctrl.instrDone = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.memWrite  = 1'b1;
            ctrl.iorD      = 1'b1;
            ctrl.instrDone = memReady;
         end
         S_EXEC_R: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_B;
            ctrl.aluOp   = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl.regWrite  = 1'b1;
            ctrl.regDst    = REGDST_RD;
            ctrl.memToReg  = M2R_ALUOUT;
            ctrl.instrDone = 1'b1;
         end
         S_EXEC_I: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            case (opQ)
               OP_ANDI: ctrl.aluOp = ALU_AND;
               OP_ORI:  ctrl.aluOp = ALU_OR;
               OP_LUI:  ctrl.aluOp = ALU_LUI;
               default: ctrl.aluOp = ALU_ADD;
            endcase
         end
         S_I_WB: begin
            ctrl.regWrite  = 1'b1;
            ctrl.regDst    = REGDST_RT;
            ctrl.memToReg  = M2R_ALUOUT;
            ctrl.instrDone = 1'b1;
         end
         S_BRANCH: begin
            ctrl.aluSrcA   = 1'b1;
            ctrl.aluSrcB   = SRCB_B;
            ctrl.aluOp     = ALU_SUB;
            ctrl.pcSource  = PCSRC_ALUOUT;
            ctrl.branchEq  = (opQ == OP_BEQ);
            ctrl.branchNe  = (opQ == OP_BNE);
            ctrl.instrDone = 1'b1;
         end
         S_JUMP: begin
            ctrl.pcWrite   = 1'b1;
            ctrl.pcSource  = PCSRC_JUMP;
            ctrl.instrDone = 1'b1;
         end
         S_JAL: begin
            ctrl.pcWrite   = 1'b1;
            ctrl.pcSource  = PCSRC_JUMP;
            ctrl.regWrite  = 1'b1;
            ctrl.regDst    = REGDST_RA;
            ctrl.memToReg  = M2R_PC;
            ctrl.instrDone = 1'b1;
         end
         default: ;
      endcase
      // Reset leaves only the FETCH mux selects visible; every enable drops.
      if (reset) begin
         ctrl.memRead   = 1'b0;
         ctrl.memWrite  = 1'b0;
         ctrl.irWrite   = 1'b0;
         ctrl.pcWrite   = 1'b0;
         ctrl.regWrite  = 1'b0;
         ctrl.branchEq  = 1'b0;
         ctrl.branchNe  = 1'b0;
         ctrl.instrDone = 1'b0;
         ctrl.illegalOp = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// MIPS multi-cycle control unit: state register, latched opcode and
// next-state sequencing, with a memory-ready handshake on memory states.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W     = 3,
   parameter int MEM_WAIT_EN = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         OP,
   input  logic               mem_ready,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               BranchEQ,
   output logic               BranchNE,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemtoReg,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         PCSource,
   output logic [3:0]         state,
   output logic               instr_done,
   output logic               illegal_op
);

   state_t     stateQ, stateD;
   logic [5:0] opQ;
   logic       memReady;
   ctrl_t      ctrl;

   assign memReady = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ <= S_FETCH;
         opQ    <= 6'd0;
      end else begin
         stateQ <= stateD;
         if (stateQ == S_DECODE) opQ <= OP;
      end
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         S_FETCH:    if (memReady) stateD = S_DECODE;
         S_DECODE: begin
            case (OP)
               OP_LW, OP_SW:                      stateD = S_MEM_ADDR;
               OP_R:                              stateD = S_EXEC_R;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  stateD = S_EXEC_I;
               OP_BEQ, OP_BNE:                    stateD = S_BRANCH;
               OP_J:                              stateD = S_JUMP;
               OP_JAL:                            stateD = S_JAL;
               default:                           stateD = S_FETCH;
            endcase
         end
         S_MEM_ADDR: stateD = (opQ == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (memReady) stateD = S_MEM_WB;
         S_MEM_WR:   if (memReady) stateD = S_FETCH;
         S_EXEC_R:   stateD = S_R_WB;
         S_EXEC_I:   stateD = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL:
                     stateD = S_FETCH;
         default:    stateD = S_FETCH;
      endcase
   end

   multicycle_control_decode uDecode (
      .state    (stateQ),
      .op       (OP),
      .opQ      (opQ),
      .memReady (memReady),
      .reset    (reset),
      .ctrl     (ctrl)
   );

   assign IorD       = ctrl.iorD;
   assign MemRead    = ctrl.memRead;
   assign MemWrite   = ctrl.memWrite;
   assign IRWrite    = ctrl.irWrite;
   assign PCWrite    = ctrl.pcWrite;
   assign BranchEQ   = ctrl.branchEq;
   assign BranchNE   = ctrl.branchNe;
   assign RegDst     = ctrl.regDst;
   assign MemtoReg   = ctrl.memToReg;
   assign RegWrite   = ctrl.regWrite;
   assign ALUSrcA    = ctrl.aluSrcA;
   assign ALUSrcB    = ctrl.aluSrcB;
   assign ALUOp      = ALUOP_W'(ctrl.aluOp);
   assign PCSource   = ctrl.pcSource;
   assign state      = stateQ;
   assign instr_done = ctrl.instrDone;
   assign illegal_op = ctrl.illegalOp;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the MIPS processor: a Moore-style state machine that sequences each instruction over 3–5 cycles and drives the datapath enables, mux selects and ALU operation. It replaces the single-cycle opcode decoder and adds a memory wait handshake (`mem_ready`) for variable-latency memory. It also adds an illegal-opcode flag and an instruction-complete pulse. It sits between the instruction register (source of `OP`) and the shared-memory multi-cycle datapath.

## Interface
- `ALUOP_W`, default 3: width of `ALUOp`; codes are zero-extended when wider.
- `MEM_WAIT_EN`, default 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored and treated as 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `OP` in 6: opcode from the instruction register.
- `mem_ready` in 1: memory access completes this cycle.
- `IorD` out 1: 0 = PC addresses memory, 1 = ALUOut addresses memory.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `IRWrite` out 1: load the instruction register.
- `PCWrite` out 1: unconditional PC load.
- `BranchEQ` out 1: PC load if ALU zero.
- `BranchNE` out 1: PC load if ALU not zero.
- `RegDst` out 2: destination register select; 0 = rt, 1 = rd, 2 = $ra.
- `MemtoReg` out 2: write-back source; 0 = ALUOut, 1 = MDR, 2 = PC.
- `RegWrite` out 1: register file write.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate shifted left 2.
- `ALUOp` out `ALUOP_W`: ALU control.
- `PCSource` out 2: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `state` out 4: current state, for debug.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE for an unsupported opcode.

## Operation
- ALUOp codes: AND 000, SUB 001, LUI 010, ADD 100, OR 101, MEMADD 110, FUNCT 111.
- Supported opcodes: R 0x00, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, ADDI 0x08, ANDI 0x0C, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B.
- State encodings:
  - FETCH 0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0. IRWrite and PCWrite are asserted only in the cycle `mem_ready`=1; that cycle exits to DECODE, otherwise the FSM holds.
  - DECODE 1: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD. `OP` is captured into `op_q`. Next state by opcode:
    - LW/SW → MEM_ADDR
    - R → EXEC_R
    - ADDI/ANDI/ORI/LUI → EXEC_I
    - BEQ/BNE → BRANCH
    - J → JUMP
    - JAL → JAL
    - other → FETCH, with `illegal_op`=1 and `instr_done`=1
  - MEM_ADDR 2: ALUSrcA=1, ALUSrcB=2, ALUOp=MEMADD. Next is MEM_RD if `op_q`=LW, else MEM_WR.
  - MEM_RD 3: MemRead=1, IorD=1. Holds until `mem_ready`, then → MEM_WB.
  - MEM_WB 4: RegWrite=1, RegDst=0, MemtoReg=1, `instr_done`; → FETCH.
  - MEM_WR 5: MemWrite=1, IorD=1. Holds until `mem_ready`; in the `mem_ready` cycle asserts `instr_done` and goes → FETCH. MemWrite stays high for every waiting cycle.
  - EXEC_R 6: ALUSrcA=1, ALUSrcB=0, ALUOp=FUNCT; → R_WB.
  - R_WB 7: RegWrite=1, RegDst=1, MemtoReg=0, `instr_done`; → FETCH.
  - EXEC_I 8: ALUSrcA=1, ALUSrcB=2, ALUOp per `op_q` (ADD/AND/OR/LUI); → I_WB.
  - I_WB 9: RegWrite=1, RegDst=0, MemtoReg=0, `instr_done`; → FETCH.
  - BRANCH 10: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1, BranchEQ or BranchNE per `op_q`, `instr_done`; → FETCH.
  - JUMP 11: PCWrite=1, PCSource=2, `instr_done`; → FETCH.
  - JAL 12: PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2, `instr_done`; → FETCH. PC already holds PC+4 at this point.
- Any undefined state encoding → FETCH on the next clock.
- Outputs not listed for a state are 0.

## Timing
- Reset: `state`=FETCH and `op_q`=0 immediately, asynchronously.
- While `reset`=1: every output is 0 except `state` (=0) and the FETCH mux selects. MemRead, IRWrite and PCWrite are forced to 0.
- First FETCH request: in the first cycle after `reset` falls.
- Zero-wait latency in cycles, FETCH through last state: LW 5, SW 4, R 4, I-type 4, BEQ/BNE 3, J 3, JAL 3, illegal 2.
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Outputs are Moore (decoded from `state`/`op_q`), except IRWrite, PCWrite and `instr_done` in FETCH/MEM_WR, which are gated combinationally by `mem_ready`.
- Reset asserted mid-instruction: the instruction is abandoned and no write enable is asserted after `reset` rises.
- `OP` changes after DECODE have no effect.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state localparams
  - opcode localparams
  - ALUOp code localparams
  - RegDst/MemtoReg/PCSource/ALUSrcB select codes
- Sub-module `multicycle_control_decode`: combinational state/`op_q`/`mem_ready` → output vector.
- The top level holds the state register, `op_q` and next-state logic.

## Test plan
- Reset pulse mid-MEM_WR with `mem_ready`=0 → MemWrite drops in the same cycle and `state`=0; the next cycle is FETCH with MemRead=1.
- `OP`=0x23 (LW), `mem_ready` held at 1 → state sequence 0,1,2,3,4. `instr_done` high only in state 4, where RegWrite=1 and MemtoReg=1.
- `OP`=0x2B (SW), `mem_ready` low for 3 cycles in MEM_WR → state 5 lasts 4 cycles with MemWrite=1 throughout; one `instr_done`; RegWrite never asserted.
- `OP`=0x05 (BNE) → 3 cycles; BRANCH drives ALUOp=001, BranchNE=1, BranchEQ=0, PCSource=1.
- `OP`=0x03 (JAL) → JAL state drives RegDst=2, MemtoReg=2, PCWrite=1, PCSource=2.
- `OP`=0x3F, then FETCH with `mem_ready` low for 2 cycles → `illegal_op`=1 for one cycle in DECODE, return to FETCH; IRWrite=0 until `mem_ready`=1. Repeat with `MEM_WAIT_EN`=0: FETCH lasts 1 cycle.
